// File: rtl/y86_decode_stage.sv
// Y86-64 decode stage: field split, source/dest IDs,
// load-use detection and the D->E pipeline register.
package y86_pkg;

  localparam logic [3:0] RNONE    = 4'hF;
  localparam logic [3:0] RSP      = 4'h4;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [1:0] S_AOK    = 2'd0;
  localparam logic [1:0] S_HLT    = 2'd1;
  localparam logic [1:0] S_INS    = 2'd2;

  typedef struct packed {
    logic        valid;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  src_a;
    logic [3:0]  src_b;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic [63:0] val_c;
    logic [63:0] val_p;
    logic [1:0]  stat;
  } id_ex_t;

  localparam id_ex_t ID_EX_BUBBLE = '{
    valid: 1'b0,
    icode: I_NOP,
    ifun:  4'h0,
    src_a: RNONE,
    src_b: RNONE,
    dst_e: RNONE,
    dst_m: RNONE,
    val_c: 64'h0,
    val_p: 64'h0,
    stat:  S_AOK
  };

endpackage

module y86_decode_stage
  import y86_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [79:0] instrD,
  input  logic [63:0] valPD,
  input  logic        validD,
  output logic        readyD,
  input  logic        flushD,
  input  logic        stallE,
  output logic [3:0]  readRegA,
  output logic [3:0]  readRegB,
  output logic        validE,
  output logic [3:0]  icodeE,
  output logic [3:0]  ifunE,
  output logic [3:0]  srcAE,
  output logic [3:0]  srcBE,
  output logic [3:0]  dstEE,
  output logic [3:0]  dstME,
  output logic [63:0] valCE,
  output logic [63:0] valPE,
  output logic [1:0]  statE
);

  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [3:0]  ra;
  logic [3:0]  rb;

  logic        is_halt;
  logic        is_rrmovq;
  logic        is_irmovq;
  logic        is_rmmovq;
  logic        is_mrmovq;
  logic        is_opq;
  logic        is_jxx;
  logic        is_call;
  logic        is_ret;
  logic        is_pushq;
  logic        is_popq;
  logic        bad;
  logic        use_ids;

  logic [3:0]  src_a;
  logic [3:0]  src_b;
  logic [3:0]  dst_e;
  logic [3:0]  dst_m;
  logic [63:0] val_c;
  logic [1:0]  stat;

  logic        e_is_load;
  logic        luh;

  id_ex_t      dec;
  id_ex_t      e_d;
  id_ex_t      e_q;

  assign icode = instrD[7:4];
  assign ifun  = instrD[3:0];
  assign ra    = instrD[15:12];
  assign rb    = instrD[11:8];

  assign is_halt   = (icode == I_HALT);
  assign is_rrmovq = (icode == I_RRMOVQ);
  assign is_irmovq = (icode == I_IRMOVQ);
  assign is_rmmovq = (icode == I_RMMOVQ);
  assign is_mrmovq = (icode == I_MRMOVQ);
  assign is_opq    = (icode == I_OPQ);
  assign is_jxx    = (icode == I_JXX);
  assign is_call   = (icode == I_CALL);
  assign is_ret    = (icode == I_RET);
  assign is_pushq  = (icode == I_PUSHQ);
  assign is_popq   = (icode == I_POPQ);
  assign bad       = (icode > I_POPQ);

  // Invalid opcodes and empty slots must never name a register.
  assign use_ids   = validD & ~bad;

  always_comb begin
    src_a = RNONE;
    if (use_ids) begin
      unique case (1'b1)
        is_rrmovq | is_rmmovq | is_opq | is_pushq:
          src_a = ra;
        is_ret | is_popq:
          src_a = RSP;
        default:
          src_a = RNONE;
      endcase
    end
  end

  always_comb begin
    src_b = RNONE;
    if (use_ids) begin
      unique case (1'b1)
        is_rmmovq | is_mrmovq | is_opq:
          src_b = rb;
        is_call | is_ret | is_pushq | is_popq:
          src_b = RSP;
        default:
          src_b = RNONE;
      endcase
    end
  end

  always_comb begin
    dst_e = RNONE;
    if (use_ids) begin
      unique case (1'b1)
        is_rrmovq | is_irmovq | is_opq:
          dst_e = rb;
        is_call | is_ret | is_pushq | is_popq:
          dst_e = RSP;
        default:
          dst_e = RNONE;
      endcase
    end
  end

  always_comb begin
    dst_m = RNONE;
    if (use_ids) begin
      unique case (1'b1)
        is_mrmovq | is_popq:
          dst_m = ra;
        default:
          dst_m = RNONE;
      endcase
    end
  end

  // Constant is little-endian; jumps/calls have no register byte.
  always_comb begin
    val_c = 64'h0;
    unique case (1'b1)
      is_irmovq | is_rmmovq | is_mrmovq:
        val_c = instrD[79:16];
      is_jxx | is_call:
        val_c = instrD[71:8];
      default:
        val_c = 64'h0;
    endcase
  end

  always_comb begin
    stat = S_AOK;
    unique case (1'b1)
      is_halt: stat = S_HLT;
      bad:     stat = S_INS;
      default: stat = S_AOK;
    endcase
  end

  assign readRegA = src_a;
  assign readRegB = src_b;

  assign e_is_load = e_q.valid &
                     ((e_q.icode == I_MRMOVQ) |
                      (e_q.icode == I_POPQ));

  assign luh = validD & e_is_load &
               (e_q.dst_m != RNONE) &
               ((e_q.dst_m == src_a) |
                (e_q.dst_m == src_b));

  assign readyD = ~luh & ~stallE;

  always_comb begin
    dec       = ID_EX_BUBBLE;
    dec.valid = 1'b1;
    dec.icode = icode;
    dec.ifun  = ifun;
    dec.src_a = src_a;
    dec.src_b = src_b;
    dec.dst_e = dst_e;
    dec.dst_m = dst_m;
    dec.val_c = val_c;
    dec.val_p = valPD;
    dec.stat  = stat;
  end

  always_comb begin
    e_d = e_q;
    if (stallE) begin
      e_d = e_q;
    end else if (flushD | luh | ~validD) begin
      e_d = ID_EX_BUBBLE;
    end else begin
      e_d = dec;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      e_q <= ID_EX_BUBBLE;
    end else begin
      e_q <= e_d;
    end
  end

  assign validE = e_q.valid;
  assign icodeE = e_q.icode;
  assign ifunE  = e_q.ifun;
  assign srcAE  = e_q.src_a;
  assign srcBE  = e_q.src_b;
  assign dstEE  = e_q.dst_e;
  assign dstME  = e_q.dst_m;
  assign valCE  = e_q.val_c;
  assign valPE  = e_q.val_p;
  assign statE  = e_q.stat;

endmodule

// File: tb/tb_y86_decode_stage.sv
// Bench for y86_decode_stage: per-cycle model compare
// plus directed literal checks.
module tb_y86_decode_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [79:0] instrD;
  logic [63:0] valPD;
  logic        validD;
  logic        flushD;
  logic        stallE;
  logic        readyD;
  logic [3:0]  readRegA;
  logic [3:0]  readRegB;
  logic        validE;
  logic [3:0]  icodeE;
  logic [3:0]  ifunE;
  logic [3:0]  srcAE;
  logic [3:0]  srcBE;
  logic [3:0]  dstEE;
  logic [3:0]  dstME;
  logic [63:0] valCE;
  logic [63:0] valPE;
  logic [1:0]  statE;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  y86_decode_stage dut (
    .clock    (clock),
    .reset    (reset),
    .instrD   (instrD),
    .valPD    (valPD),
    .validD   (validD),
    .readyD   (readyD),
    .flushD   (flushD),
    .stallE   (stallE),
    .readRegA (readRegA),
    .readRegB (readRegB),
    .validE   (validE),
    .icodeE   (icodeE),
    .ifunE    (ifunE),
    .srcAE    (srcAE),
    .srcBE    (srcBE),
    .dstEE    (dstEE),
    .dstME    (dstME),
    .valCE    (valCE),
    .valPE    (valPE),
    .statE    (statE)
  );

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference rules straight from the instruction tables
  function automatic logic [3:0] f_src_a(input logic [79:0] i,
                                         input logic v);
    logic [3:0] c;
    c = i[7:4];
    if (!v) return 4'hF;
    if (c inside {4'h2, 4'h4, 4'h6, 4'hA}) return i[15:12];
    if (c inside {4'h9, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] f_src_b(input logic [79:0] i,
                                         input logic v);
    logic [3:0] c;
    c = i[7:4];
    if (!v) return 4'hF;
    if (c inside {4'h4, 4'h5, 4'h6}) return i[11:8];
    if (c inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] f_dst_e(input logic [79:0] i,
                                         input logic v);
    logic [3:0] c;
    c = i[7:4];
    if (!v) return 4'hF;
    if (c inside {4'h2, 4'h3, 4'h6}) return i[11:8];
    if (c inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] f_dst_m(input logic [79:0] i,
                                         input logic v);
    logic [3:0] c;
    c = i[7:4];
    if (!v) return 4'hF;
    if (c inside {4'h5, 4'hB}) return i[15:12];
    return 4'hF;
  endfunction

  function automatic logic [63:0] f_val_c(input logic [79:0] i);
    logic [3:0]  c;
    logic [63:0] v;
    logic [63:0] b;
    int          first;
    c = i[7:4];
    if (c inside {4'h3, 4'h4, 4'h5}) first = 2;
    else if (c inside {4'h7, 4'h8}) first = 1;
    else return 64'h0;
    v = 64'h0;
    for (int k = 0; k < 8; k++) begin
      b = 64'(i[8*(first+k) +: 8]);
      v = v | (b << (8*k));
    end
    return v;
  endfunction

  function automatic logic [1:0] f_stat(input logic [79:0] i);
    if (i[7:4] == 4'h0) return 2'd1;
    if (i[7:4] > 4'hB) return 2'd2;
    return 2'd0;
  endfunction

  logic        mv;
  logic [3:0]  mic, mif, msa, msb, mde, mdm;
  logic [63:0] mvc, mvp;
  logic [1:0]  mst;

  function automatic bit m_luh();
    logic [3:0] a;
    logic [3:0] b;
    a = f_src_a(instrD, validD);
    b = f_src_b(instrD, validD);
    return mv && (mic == 4'h5 || mic == 4'hB) &&
           mdm != 4'hF && validD === 1'b1 &&
           (mdm == a || mdm == b);
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mv <= 0; mic <= 4'h1; mif <= 0;
      msa <= 4'hF; msb <= 4'hF; mde <= 4'hF; mdm <= 4'hF;
      mvc <= 0; mvp <= 0; mst <= 0;
    end else if (stallE) begin
      mv <= mv;
    end else if (flushD || m_luh() || !validD) begin
      mv <= 0; mic <= 4'h1; mif <= 0;
      msa <= 4'hF; msb <= 4'hF; mde <= 4'hF; mdm <= 4'hF;
      mvc <= 0; mvp <= 0; mst <= 0;
    end else begin
      mv  <= 1'b1;
      mic <= instrD[7:4];
      mif <= instrD[3:0];
      msa <= f_src_a(instrD, 1'b1);
      msb <= f_src_b(instrD, 1'b1);
      mde <= f_dst_e(instrD, 1'b1);
      mdm <= f_dst_m(instrD, 1'b1);
      mvc <= f_val_c(instrD);
      mvp <= valPD;
      mst <= f_stat(instrD);
    end
  end

  always @(negedge clock) begin
    chk("readRegA", 64'(readRegA), 64'(f_src_a(instrD, validD)));
    chk("readRegB", 64'(readRegB), 64'(f_src_b(instrD, validD)));
    chk("readyD", 64'(readyD), 64'(!m_luh() && !stallE));
    chk("validE", 64'(validE), 64'(mv));
    chk("icodeE", 64'(icodeE), 64'(mic));
    chk("ifunE", 64'(ifunE), 64'(mif));
    chk("srcAE", 64'(srcAE), 64'(msa));
    chk("srcBE", 64'(srcBE), 64'(msb));
    chk("dstEE", 64'(dstEE), 64'(mde));
    chk("dstME", 64'(dstME), 64'(mdm));
    chk("valCE", valCE, mvc);
    chk("valPE", valPE, mvp);
    chk("statE", 64'(statE), 64'(mst));
  end

  function automatic logic [79:0] mk(input logic [7:0] b0,
                                     input logic [7:0] b1,
                                     input logic [63:0] vc);
    return {vc, b1, b0};
  endfunction

  function automatic logic [79:0] mkj(input logic [7:0] b0,
                                      input logic [63:0] vc);
    return {8'h00, vc, b0};
  endfunction

  task automatic drive(input logic [79:0] i, input logic v,
                       input logic f, input logic s);
    instrD = i;
    validD = v;
    flushD = f;
    stallE = s;
    valPD  = valPD + 64'd10;
    #1;
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  initial begin
    reset  = 1'b0;
    instrD = mk(8'h30, 8'hF1, 64'h8c0f000b);
    valPD  = 64'h100;
    validD = 1'b1;
    flushD = 1'b0;
    stallE = 1'b0;
    repeat (2) tick();
    chk("rst_validE", 64'(validE), 64'h0);
    chk("rst_icodeE", 64'(icodeE), 64'h1);
    chk("rst_srcAE", 64'(srcAE), 64'hF);
    chk("rst_dstEE", 64'(dstEE), 64'hF);
    chk("rst_valCE", valCE, 64'h0);

    reset = 1'b1;
    tick();
    chk("irm_icodeE", 64'(icodeE), 64'h3);
    chk("irm_dstEE", 64'(dstEE), 64'h1);
    chk("irm_srcAE", 64'(srcAE), 64'hF);
    chk("irm_valCE", valCE, 64'h8c0f000b);

    drive(mk(8'h60, 8'h23, 0), 1, 0, 0);
    chk("opq_rra", 64'(readRegA), 64'h2);
    chk("opq_rrb", 64'(readRegB), 64'h3);
    tick();
    chk("opq_dstEE", 64'(dstEE), 64'h3);

    drive(mk(8'hA0, 8'h1F, 0), 1, 0, 0);
    chk("push_rra", 64'(readRegA), 64'h1);
    chk("push_rrb", 64'(readRegB), 64'h4);
    tick();
    chk("push_dstEE", 64'(dstEE), 64'h4);

    drive(mk(8'h50, 8'h02, 64'h8), 1, 0, 0);
    tick();
    chk("mrm_dstME", 64'(dstME), 64'h0);
    chk("mrm_valCE", valCE, 64'h8);
    drive(mk(8'h60, 8'h03, 0), 1, 0, 0);
    chk("luh_readyD", 64'(readyD), 64'h0);
    tick();
    chk("luh_bubble", 64'(validE), 64'h0);
    chk("luh_ready2", 64'(readyD), 64'h1);
    tick();
    chk("luh_icodeE", 64'(icodeE), 64'h6);
    chk("luh_srcAE", 64'(srcAE), 64'h0);

    drive(mk(8'hB0, 8'h0F, 0), 1, 0, 0);
    tick();
    drive(mk(8'h20, 8'h12, 0), 1, 0, 0);
    chk("nofalse_rdy", 64'(readyD), 64'h1);
    tick();
    chk("nofalse_vE", 64'(validE), 64'h1);
    chk("nofalse_ic", 64'(icodeE), 64'h2);

    drive(mk(8'h60, 8'h23, 0), 1, 1, 1);
    chk("stfl_readyD", 64'(readyD), 64'h0);
    tick();
    chk("stfl_icodeE", 64'(icodeE), 64'h2);
    chk("stfl_validE", 64'(validE), 64'h1);
    drive(mk(8'h60, 8'h23, 0), 1, 1, 0);
    tick();
    chk("flush_validE", 64'(validE), 64'h0);

    drive(mk(8'hC0, 8'h00, 0), 1, 0, 0);
    tick();
    chk("ins_statE", 64'(statE), 64'h2);
    chk("ins_srcAE", 64'(srcAE), 64'hF);
    chk("ins_dstEE", 64'(dstEE), 64'hF);
    drive(mk(8'h00, 8'h00, 0), 1, 0, 0);
    tick();
    chk("hlt_statE", 64'(statE), 64'h1);
    chk("hlt_icodeE", 64'(icodeE), 64'h0);
    drive(mk(8'h10, 8'h00, 0), 1, 0, 0);
    tick();
    chk("after_hlt_v", 64'(validE), 64'h1);

    drive(mkj(8'h73, 64'h1122334455667788), 1, 0, 0);
    tick();
    chk("jxx_valCE", valCE, 64'h1122334455667788);
    chk("jxx_ifunE", 64'(ifunE), 64'h3);
    drive(mkj(8'h80, 64'h40), 1, 0, 0);
    tick();
    chk("call_dstEE", 64'(dstEE), 64'h4);
    chk("call_srcBE", 64'(srcBE), 64'h4);

    drive(mk(8'h50, 8'h02, 64'h8), 1, 0, 0);
    tick();
    drive(mk(8'h60, 8'h03, 0), 1, 0, 1);
    chk("stluh_rdy", 64'(readyD), 64'h0);
    tick();
    chk("stluh_hold", 64'(icodeE), 64'h5);
    stallE = 1'b0;
    #1;
    chk("stluh_rdy2", 64'(readyD), 64'h0);
    tick();
    chk("stluh_bub", 64'(validE), 64'h0);
    tick();
    chk("stluh_load", 64'(icodeE), 64'h6);

    drive(mk(8'hB0, 8'h0F, 0), 1, 0, 0);
    tick();
    drive(mk(8'h60, 8'h03, 0), 1, 1, 0);
    chk("flluh_rdy", 64'(readyD), 64'h0);
    tick();
    chk("flluh_bub", 64'(validE), 64'h0);

    drive(mk(8'h60, 8'h23, 0), 0, 0, 0);
    chk("inv_rra", 64'(readRegA), 64'hF);
    chk("inv_rrb", 64'(readRegB), 64'hF);
    tick();
    chk("inv_validE", 64'(validE), 64'h0);

    drive(mk(8'h30, 8'hF5, 64'h77), 1, 0, 0);
    tick();
    chk("pre_ar_vE", 64'(validE), 64'h1);
    reset = 1'b0;
    #1;
    chk("ar_validE", 64'(validE), 64'h0);
    chk("ar_icodeE", 64'(icodeE), 64'h1);
    tick();
    reset = 1'b1;
    tick();
    chk("post_ar_vE", 64'(validE), 64'h1);
    chk("post_ar_dE", 64'(dstEE), 64'h5);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/y86_decode_stage.md
# y86_decode_stage

Decode stage of the Y86-64 pipeline, placed between fetch and the `Register` file and execute stage. It splits a fetched instruction into icode/ifun/rA/rB/valC, computes the register-file source IDs, and drives the register-file read addresses. It detects load-use hazards against the instruction currently in execute. Results are latched into the D→E pipeline register, with stall, bubble and flush control.

## Interface
- `RNONE`, 4'hF: register ID meaning "no register".
- `RSP`, 4'h4: stack pointer register ID.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low; clears the D→E register to a bubble.
- `instrD` in 80: fetched instruction bytes; byte0 = `instrD[7:0]` = {icode[7:4], ifun[3:0]}, byte1 = {rA[7:4], rB[3:0]}.
- `valPD` in 64: address of the next sequential instruction.
- `validD` in 1: `instrD`/`valPD` hold a real instruction.
- `readyD` out 1: decode accepts this cycle; low means fetch must hold.
- `flushD` in 1: squash the decode instruction (mispredict); E loads a bubble.
- `stallE` in 1: hold the E register unchanged.
- `readRegA`, `readRegB` out 4 each: combinational srcA/srcB, wired to `Register.readRegA/B`.
- `validE` out 1: E holds a real instruction.
- `icodeE`, `ifunE` out 4 each.
- `srcAE`, `srcBE`, `dstEE`, `dstME` out 4 each.
- `valCE`, `valPE` out 64 each.
- `statE` out 2: 0 = AOK, 1 = HLT, 2 = INS (invalid instruction).

## Operation
- The instruction is decoded combinationally from `instrD`. valC is little-endian: bytes 2..9 for icode 3, 4 and 5; bytes 1..8 for icode 7 and 8; 0 otherwise.
- srcA:
  - rA for icode 2, 4, 6, A.
  - RSP for icode 9, B.
  - RNONE otherwise.
- srcB:
  - rB for icode 4, 5, 6.
  - RSP for icode 8, 9, A, B.
  - RNONE otherwise.
- dstE:
  - rB for icode 2, 3, 6.
  - RSP for icode 8, 9, A, B.
  - RNONE otherwise.
- dstM: rA for icode 5, B; RNONE otherwise.
- When `validD` = 0, all of the above are RNONE, and `readRegA`/`readRegB` = RNONE.
- Load-use hazard `luh` is true when all of the following hold:
  - `validE` = 1;
  - `icodeE` is 5 or B;
  - `dstME` ≠ RNONE;
  - `dstME` equals the decode srcA or srcB;
  - `validD` = 1.
- `readyD` = !`luh` & !`stallE`.
- E register update priority, highest first:
  1. reset → bubble.
  2. `stallE` → hold.
  3. `flushD` or `luh` or !`validD` → bubble.
  4. Otherwise, load the decoded fields, `valPD`, and stat.
- Bubble contents: `validE`=0, `icodeE`=1 (nop), `ifunE`=0, all register IDs = RNONE, `valCE`=`valPE`=0, `statE`=0.
- stat:
  - HLT for icode 0.
  - INS for icode > B, in which case all IDs are forced to RNONE.
  - AOK otherwise.
- Once a HLT or INS instruction is loaded into E, subsequent instructions still load normally; halting is owned downstream.
- ifun is not checked here.

## Timing
- Reset values of registered outputs equal the bubble contents.
- `readRegA`, `readRegB` and `readyD` are combinational and have zero latency.
- The register-file read completes in the same cycle.
- Decode→E latency is 1 cycle.
- A load-use hazard costs exactly 1 bubble cycle:
  - Cycle n: `luh` = 1, `readyD` = 0, and E receives a bubble at the edge.
  - Cycle n+1: `luh` clears, because E now holds the bubble, and the held instruction loads at the next edge.
- Fetch holds `instrD` and `validD` while `readyD` = 0.
- `stallE` with `luh` both high: E holds, `readyD` = 0.
- `flushD` with `luh` both high: bubble (same result as either alone). `readyD` follows the formula above; fetch replaces the instruction on a flush regardless of `readyD`.
- Reset asserted mid-operation clears E asynchronously with no edge required. The first load happens on the first rising edge after `reset` goes high.

## Test plan
- Reset: `reset`=0 with `validD`=1 → `validE`=0, `icodeE`=1, IDs F, `valCE`=0. After release, with `instrD` = irmovq 0x8c0f000b,%rcx (bytes 30 F1 0b 00 0f 8c 00…), the next edge gives `icodeE`=3, `dstEE`=1, `srcAE`=F, `valCE`=64'h8c0f000b.
- Source decode: OPq rA=2, rB=3 (bytes 60 23) → `readRegA`=2, `readRegB`=3, and after the edge `dstEE`=3. pushq rA=1 (A0 1F) → `readRegA`=1, `readRegB`=4, `dstEE`=4.
- Load-use: mrmovq 8(%rdx),%rax (50 02 …) followed by addq %rax,%rbx (60 03) → one cycle with `readyD`=0 and a bubble in E. The addq reaches E the following cycle with `srcAE`=0.
- No false hazard: popq %rax in E with rrmovq %rcx,%rdx in decode → `readyD`=1 and no bubble.
- Priority: `stallE`=1 with `flushD`=1 → E unchanged. `flushD`=1 alone → `validE`=0 next cycle.
- Invalid/halt: byte0 = C0 → `statE`=2, IDs F. byte0 = 00 → `statE`=1, `icodeE`=0.
